// File: rtl/blit_pkg.sv
// Shared encodings for the blitter memory arbiter: FSM state and the
// identity of the requester that owns the in-flight memory access.
package blit_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_CPU  = 1'b1
    } owner_t;

    localparam logic [1:0] BE_ALL = 2'b11;

endpackage

// File: rtl/blit_memarb.sv
// Two-requester memory arbiter: display fetches take priority, but a waiting
// CPU access is forced through after DISP_BURST_MAX consecutive display grants.
module blit_memarb
    import blit_pkg::*;
#(
    parameter int DISP_BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        disp_req,
    input  logic [17:0] disp_addr,
    output logic        disp_ack,
    output logic [15:0] disp_rdata,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [17:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic [1:0]  cpu_be,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [17:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_be,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);

    localparam logic [3:0] BURST_MAX = 4'(DISP_BURST_MAX);

    state_t      r_state;
    state_t      w_state_nxt;
    owner_t      r_owner;
    logic        r_disp_pend;
    logic [17:0] r_disp_addr;
    logic [3:0]  r_burst_cnt;
    logic        r_mem_req;
    logic        r_mem_wr;
    logic [17:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic [1:0]  r_mem_be;
    logic        r_disp_ack;
    logic        r_cpu_ack;
    logic [15:0] r_disp_rdata;
    logic [15:0] r_cpu_rdata;

    logic        w_disp_pend;
    logic [17:0] w_disp_addr;
    logic        w_cpu_live;
    logic        w_grant_disp;
    logic        w_grant_cpu;
    logic        w_mem_done;

    // A fresh disp_req can be granted in the cycle it arrives.
    assign w_disp_pend = r_disp_pend | disp_req;
    assign w_disp_addr = r_disp_pend ? r_disp_addr : disp_addr;
    // cpu_req is still high in its ack cycle; it must not win a second grant.
    assign w_cpu_live  = cpu_req & ~r_cpu_ack;
    assign w_mem_done  = (r_state == ST_BUSY) && mem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_disp = 1'b0;
        w_grant_cpu  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_disp_pend && !(w_cpu_live && r_burst_cnt == BURST_MAX)) begin
                    w_grant_disp = 1'b1;
                    w_state_nxt  = ST_BUSY;
                end else if (w_cpu_live) begin
                    w_grant_cpu  = 1'b1;
                    w_state_nxt  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_pend  <= 1'b0;
            r_disp_addr  <= '0;
            r_burst_cnt  <= '0;
            r_owner      <= OWN_DISP;
            r_mem_req    <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= '0;
        end else begin
            // A request already latched is consumed by the grant; a second
            // pulse in the same cycle becomes the next pending fetch.
            if (w_grant_disp) begin
                r_disp_pend <= r_disp_pend & disp_req;
            end else if (disp_req) begin
                r_disp_pend <= 1'b1;
            end
            if (disp_req && (!r_disp_pend || w_grant_disp)) begin
                r_disp_addr <= disp_addr;
            end

            if (!cpu_req || w_grant_cpu) begin
                r_burst_cnt <= '0;
            end else if (w_grant_disp && r_burst_cnt != BURST_MAX) begin
                r_burst_cnt <= r_burst_cnt + 4'd1;
            end

            if (w_grant_disp) begin
                r_owner     <= OWN_DISP;
                r_mem_req   <= 1'b1;
                r_mem_wr    <= 1'b0;
                r_mem_addr  <= w_disp_addr;
                r_mem_wdata <= '0;
                r_mem_be    <= BE_ALL;
            end else if (w_grant_cpu) begin
                r_owner     <= OWN_CPU;
                r_mem_req   <= 1'b1;
                r_mem_wr    <= cpu_wr;
                r_mem_addr  <= cpu_addr;
                r_mem_wdata <= cpu_wdata;
                r_mem_be    <= cpu_be;
            end else if (w_mem_done) begin
                r_mem_req   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_ack   <= 1'b0;
            r_cpu_ack    <= 1'b0;
            r_disp_rdata <= '0;
            r_cpu_rdata  <= '0;
        end else begin
            r_disp_ack <= w_mem_done && (r_owner == OWN_DISP);
            r_cpu_ack  <= w_mem_done && (r_owner == OWN_CPU);
            if (w_mem_done && r_owner == OWN_DISP) begin
                r_disp_rdata <= mem_rdata;
            end
            if (w_mem_done && r_owner == OWN_CPU) begin
                r_cpu_rdata <= r_mem_wr ? 16'h0000 : mem_rdata;
            end
        end
    end

    assign disp_ack   = r_disp_ack;
    assign disp_rdata = r_disp_rdata;
    assign cpu_ack    = r_cpu_ack;
    assign cpu_rdata  = r_cpu_rdata;
    assign mem_req    = r_mem_req;
    assign mem_wr     = r_mem_wr;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_be     = r_mem_be;

endmodule
